// File: rtl/sign_mag_converter.sv
// Sequential two's-complement to sign-magnitude converter, CHUNK bits per cycle, LSB chunk first.
// Optional overflow flag port ovf is enabled by defining SIGN_MAG_OVF_EN.
module sign_mag_converter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-1:0] mag
`ifdef SIGN_MAG_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [CHUNK-1:0] chunk;
    logic [CHUNK-1:0] res;
    logic             carry_nxt;
    logic [WIDTH-1:0] mag_rot;

    // mag is used as a rotating register: the low chunk is converted and
    // reinserted at the top, so after NCHUNK steps every chunk is back in place.
    always_comb begin
        chunk     = mag[CHUNK-1:0];
        res       = chunk;
        carry_nxt = carry;
        if (sign) begin
            {carry_nxt, res} = {1'b0, ~chunk} + {{CHUNK{1'b0}}, carry};
        end
        mag_rot = (mag >> CHUNK) | (WIDTH'(res) << (WIDTH - CHUNK));
    end

`ifdef SIGN_MAG_OVF_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic ovf_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) ovf_pend <= (x == MOST_NEG);
                CONV: if (cnt == LAST) ovf <= ovf_pend;
                DONE: if (out_ready) ovf <= 1'b0;
                default: ovf <= 1'b0;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            mag       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag      <= x;
                        sign     <= x[WIDTH-1];
                        cnt      <= '0;
                        carry    <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    mag   <= mag_rot;
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Retiring edge returns to IDLE only; acceptance waits one more edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_mag_converter.sv
// Directed bench for sign_mag_converter; ovf checks apply when SIGN_MAG_OVF_EN is defined.
module tb_sign_mag_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [31:0] mag;
`ifdef SIGN_MAG_OVF_EN
    logic        ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    sign_mag_converter #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .mag       (mag)
`ifdef SIGN_MAG_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, measure latency to out_valid, check result, retire it.
    task automatic run_op(input string tag, input logic [31:0] xin,
                          input logic exp_sign, input logic [31:0] exp_mag, input logic exp_ovf);
        int lat;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        x         = xin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".busy"}, 32'(in_ready), 32'd0);
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".sign"}, 32'(sign), 32'(exp_sign));
        check({tag, ".mag"}, mag, exp_mag);
`ifdef SIGN_MAG_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        tick();
        check({tag, ".retired"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] ops[3];
    logic        exp_s[3];
    logic [31:0] exp_m[3];
    int got, sent, last_cyc, seen_valid;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.sign", 32'(sign), 32'd0);
        check("rst.mag", mag, 32'd0);
`ifdef SIGN_MAG_OVF_EN
        check("rst.ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;

        run_op("neg10", 32'hFFFF_FFF6, 1'b1, 32'h0000_000A, 1'b0);
        run_op("pos", 32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0);
        run_op("most_neg", 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1);
        run_op("zero", 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);

        // Result held while the consumer stalls.
        tick();
        x         = 32'hFFFF_FF00;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("hold.out_valid", 32'(out_valid), 32'd1);
            check("hold.sign", 32'(sign), 32'd1);
            check("hold.mag", mag, 32'h0000_0100);
            check("hold.in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        check("hold.last_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("hold.released_valid", 32'(out_valid), 32'd0);
        check("hold.released_ready", 32'(in_ready), 32'd1);

        // Reset mid-conversion discards the operand.
        x        = 32'hFFFF_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.mag", mag, 32'd0);
        #2;
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen_valid = 1;
        end
        check("midrst.no_valid", 32'(seen_valid), 32'd0);
        run_op("after_rst", 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0);

        // Back-to-back with in_valid held high.
        ops[0] = 32'h0000_0005; exp_s[0] = 1'b0; exp_m[0] = 32'h0000_0005;
        ops[1] = 32'hFFFF_FF80; exp_s[1] = 1'b1; exp_m[1] = 32'h0000_0080;
        ops[2] = 32'h7FFF_FFFF; exp_s[2] = 1'b0; exp_m[2] = 32'h7FFF_FFFF;
        got = 0;
        sent = 0;
        last_cyc = 0;
        x         = ops[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 40 && got < 3; cyc++) begin
            logic was_ready;
            was_ready = in_ready;
            tick();
            if (was_ready && sent < 3) begin
                sent++;
                x = (sent < 3) ? ops[sent] : 32'h0;
                if (sent == 3) in_valid = 1'b0;
            end
            if (out_valid) begin
                check("b2b.sign", 32'(sign), 32'(exp_s[got]));
                check("b2b.mag", mag, exp_m[got]);
                if (got > 0) check("b2b.interval", 32'(cyc - last_cyc), 32'd6);
                last_cyc = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        check("b2b.count", 32'(got), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
